sdram_rw_arbiter: RTL
=====================

# sdram_rw_arbiter

Shares the single Avalon-MM SDRAM master port between a read requester (sample fetch) and a write requester (filtered-result writeback) in the filter accelerator. It tracks outstanding pipelined reads so returned data never exceeds the consumer buffer. It bounds consecutive same-direction transfers so neither stream starves. It sits between the filter sequencer's fetch/writeback logic and the SDRAM interconnect.

## Interface
- ADDR_W, 24, SDRAM word address width
- DATA_W, 32, data width
- MAX_OUTSTANDING, 16, max reads accepted but not yet returned (consumer buffer depth must be at least this)
- READ_BURST, 8, consecutive read accepts before yielding to a pending write
- WRITE_BURST, 4, consecutive write accepts before yielding to a pending read
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd_req  in  1  read request; held with rd_addr stable until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  read accepted this cycle
- rd_data  out  DATA_W  returned read data (av_readdata passthrough)
- rd_valid  out  1  rd_data valid (av_readdatavalid passthrough)
- wr_req  in  1  write request; held with wr_addr/wr_data stable until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  write accepted this cycle
- av_address  out  ADDR_W  master address
- av_read  out  1  master read
- av_write  out  1  master write
- av_writedata  out  DATA_W  master write data
- av_readdata  in  DATA_W  slave read data
- av_readdatavalid  in  1  slave read data valid
- av_waitrequest  in  1  slave stall
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
- state_o  out  2  0 IDLE, 1 READ, 2 WRITE

## Operation
- States: IDLE, READ, WRITE. Reset: state IDLE, burst count 0, outstanding 0, last_served = WRITE. av_read, av_write, rd_ack and wr_ack are 0 in IDLE.
- rd_eligible = rd_req & (outstanding < MAX_OUTSTANDING). A readdatavalid in the same cycle does not count toward eligibility.
- IDLE: both rd_eligible and wr_req: grant the opposite of last_served. Only one of them: grant it. Neither: stay in IDLE. Entering READ or WRITE clears the burst count and sets last_served.
- READ:
  - av_read = rd_eligible; av_address = rd_addr.
  - rd_ack = av_read & ~av_waitrequest. Each ack increments the burst count, saturating at READ_BURST.
  - Exit to IDLE at an edge where av_read = 0, or where an ack occurs with post-increment count ≥ READ_BURST and wr_req = 1.
  - av_read is never deasserted while av_waitrequest = 1 and rd_req is held.
- WRITE: mirror of READ. Use wr_req in place of rd_eligible (no credit check), drive av_writedata = wr_data, use WRITE_BURST, and yield on rd_eligible.
- Outstanding counter: +1 on rd_ack, −1 on av_readdatavalid, unchanged when both occur. It saturates at 0 if data arrives with the counter at 0, and that data is still forwarded on rd_valid.
- No address hazard checking between streams. Requesters guarantee they do not write an address with a read still outstanding.
- Reset mid-transfer: all state cleared next edge and the master strobes drop. Late readdatavalid after reset is forwarded and does not underflow the counter.

## Timing
- Command outputs are combinational from the requester inputs and the registered state. A granted request is presented on the same cycle it is sampled in READ or WRITE.
- IDLE → grant costs 1 cycle. A direction change costs 1 bubble cycle (through IDLE).
- Back-to-back accepts: 1 per cycle while the request is held, waitrequest is low, and credit is available.
- rd_valid/rd_data have zero added latency from av_readdatavalid.

## Structure
- Shared package sdram_arb_pkg: state enum (IDLE/READ/WRITE), ADDR_W and DATA_W defaults.
- One sub-module, sdram_credit_counter. It is an up/down counter with saturation at 0 and MAX, inc/dec inputs, count and has_credit outputs.
- Arbitration FSM and mux stay in the top level.

## Test plan
- Only rd_req, 20 reads, waitrequest low, readdatavalid 3 cycles after each ack → 20 consecutive rd_acks after a 1-cycle IDLE grant, outstanding peaks at 3 and returns to 0.
- Only rd_req, no readdatavalid → exactly 16 acks, then av_read = 0 and state IDLE. One readdatavalid → exactly one more ack.
- rd_req and wr_req held continuously → repeating pattern of 8 read acks, 1 bubble, 4 write acks, 1 bubble. Write addresses and data appear on the bus unchanged.
- Write pending, waitrequest held high for 5 cycles during the 8th read → av_read and av_address stay stable, then ack, then switch to WRITE.
- readdatavalid and rd_ack in the same cycle with outstanding = 5 → outstanding remains 5.
- reset asserted with 4 reads outstanding → next cycle state IDLE, outstanding 0, strobes low. 4 late readdatavalids are forwarded on rd_valid and outstanding stays 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM read/write arbiter.
// The grant helper encodes the alternate-on-conflict rule used from IDLE.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  // Pick the next direction from IDLE; a conflict goes to whoever was not served last.
  function automatic arb_state_e grant_dir(input logic rd_ok, input logic wr_ok,
                                           input logic last_was_write);
    arb_state_e g;
    if (rd_ok && wr_ok) begin
      if (last_was_write) begin
        g = ST_READ;
      end else begin
        g = ST_WRITE;
      end
    end else if (rd_ok) begin
      g = ST_READ;
    end else if (wr_ok) begin
      g = ST_WRITE;
    end else begin
      g = ST_IDLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/sdram_arb_credit_counter.sv
// Up/down count of reads in flight, saturating at 0 and MAX.
// has_credit is low once MAX reads are outstanding.
module sdram_credit_counter #(
  parameter int MAX = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       has_credit
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_r;

  // Count register; simultaneous inc and dec cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count_r != MAX_C) begin
            count_r <= count_r + CW'(1);
          end else begin
            count_r <= count_r;
          end
        end
        2'b01: begin
          if (count_r != {CW{1'b0}}) begin
            count_r <= count_r - CW'(1);
          end else begin
            count_r <= count_r;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign count      = count_r;
  assign has_credit = (count_r < MAX_C);

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Arbitrates one Avalon-MM SDRAM master between a read and a write requester,
// limiting reads in flight and bounding same-direction runs.
module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_OUTSTANDING = 16,
  parameter int READ_BURST      = 8,
  parameter int WRITE_BURST     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   rd_req,
  input  logic [ADDR_W-1:0]                      rd_addr,
  output logic                                   rd_ack,
  output logic [DATA_W-1:0]                      rd_data,
  output logic                                   rd_valid,
  input  logic                                   wr_req,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [DATA_W-1:0]                      wr_data,
  output logic                                   wr_ack,
  output logic [ADDR_W-1:0]                      av_address,
  output logic                                   av_read,
  output logic                                   av_write,
  output logic [DATA_W-1:0]                      av_writedata,
  input  logic [DATA_W-1:0]                      av_readdata,
  input  logic                                   av_readdatavalid,
  input  logic                                   av_waitrequest,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic [1:0]                             state_o
);

  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int BURST_MAX = (READ_BURST > WRITE_BURST) ? READ_BURST : WRITE_BURST;
  localparam int BW        = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] RD_LIM = BW'(READ_BURST);
  localparam logic [BW-1:0] WR_LIM = BW'(WRITE_BURST);

  arb_state_e        state_r, state_nx_s;
  logic [BW-1:0]     burst_r, burst_nx_s, burst_inc_s;
  logic              last_wr_r, last_wr_nx_s;
  logic              has_credit_s, rd_eligible_s;
  logic              rd_ack_s, wr_ack_s, av_read_s, av_write_s;
  logic [ADDR_W-1:0] av_address_s;
  logic [OUT_W-1:0]  count_s;

  sdram_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .inc        (rd_ack_s),
    .dec        (av_readdatavalid),
    .count      (count_s),
    .has_credit (has_credit_s)
  );

  // Eligibility uses the registered count, so returning data cannot free a slot this cycle.
  assign rd_eligible_s = rd_req & has_credit_s;

  // Arbitration state, run length and fairness memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      burst_r   <= {BW{1'b0}};
      last_wr_r <= 1'b1;
    end else begin
      state_r   <= state_nx_s;
      burst_r   <= burst_nx_s;
      last_wr_r <= last_wr_nx_s;
    end
  end

  // Next state plus the combinational command/ack outputs.
  always_comb begin
    state_nx_s   = state_r;
    burst_nx_s   = burst_r;
    last_wr_nx_s = last_wr_r;
    burst_inc_s  = burst_r;
    av_read_s    = 1'b0;
    av_write_s   = 1'b0;
    rd_ack_s     = 1'b0;
    wr_ack_s     = 1'b0;
    av_address_s = rd_addr;
    case (state_r)
      ST_IDLE: begin
        state_nx_s = grant_dir(rd_eligible_s, wr_req, last_wr_r);
        if (state_nx_s != ST_IDLE) begin
          burst_nx_s   = {BW{1'b0}};
          last_wr_nx_s = (state_nx_s == ST_WRITE);
        end else begin
          burst_nx_s   = burst_r;
        end
      end
      ST_READ: begin
        av_read_s    = rd_eligible_s;
        av_address_s = rd_addr;
        rd_ack_s     = rd_eligible_s & ~av_waitrequest;
        burst_inc_s  = (burst_r >= RD_LIM) ? RD_LIM : burst_r + BW'(1);
        if (rd_ack_s) begin
          burst_nx_s = burst_inc_s;
          if ((burst_inc_s >= RD_LIM) && wr_req) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_READ;
          end
        end else if (!av_read_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_READ;
        end
      end
      ST_WRITE: begin
        av_write_s   = wr_req;
        av_address_s = wr_addr;
        wr_ack_s     = wr_req & ~av_waitrequest;
        burst_inc_s  = (burst_r >= WR_LIM) ? WR_LIM : burst_r + BW'(1);
        if (wr_ack_s) begin
          burst_nx_s = burst_inc_s;
          if ((burst_inc_s >= WR_LIM) && rd_eligible_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_WRITE;
          end
        end else if (!av_write_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WRITE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        burst_nx_s = {BW{1'b0}};
      end
    endcase
  end

  assign rd_ack       = rd_ack_s;
  assign wr_ack       = wr_ack_s;
  assign av_read      = av_read_s;
  assign av_write     = av_write_s;
  assign av_address   = av_address_s;
  assign av_writedata = wr_data;
  assign rd_data      = av_readdata;
  assign rd_valid     = av_readdatavalid;
  assign outstanding  = count_s;
  assign state_o      = state_r;

endmodule
